op_fetch_assembler: RTL and testbench

- Sequential front-end between the memory byte port and the 6809/6309 execution sequencer.
- Consumes a stream of opcode bytes and assembles complete instructions: page prefix, opcode, indexed postbyte, and 0–2 operand bytes.
- Pushes each instruction record into a parametrised queue, so execution pops fully formed instructions instead of fetching byte by byte.
- Applies the same page1/page2/page3 length rules as the opcode and EA-postbyte decoders, in a stateful, back-pressured form.

---
 rtl/op_fetch_assembler_if.sv | 30 +++
 rtl/op_fetch_assembler.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_op_fetch_assembler.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/op_fetch_assembler_if.sv
// Byte-in / instruction-record-out bundle between the memory byte port,
// the fetch assembler and the 6809/6309 execution sequencer.
interface op_fetch_assembler_if #(
    parameter int PC_W = 16
);
    logic            in_valid;
    logic [7:0]      in_byte;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_page;
    logic [7:0]      out_opcode;
    logic [7:0]      out_postbyte;
    logic [15:0]     out_operand;
    logic [2:0]      out_len;
    logic            out_illegal;
    logic [PC_W-1:0] out_pc;

    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_page, out_opcode, out_postbyte,
               out_operand, out_len, out_illegal, out_pc
    );

    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_page, out_opcode, out_postbyte,
               out_operand, out_len, out_illegal, out_pc
    );
endinterface

// File: rtl/op_fetch_assembler.sv
// Assembles 6809/6309 opcode bytes into whole instruction records (prefix,
// opcode, postbyte, operand) and queues them for the execution sequencer.
module op_fetch_assembler #(
    parameter int QDEPTH     = 2,
    parameter int PC_W       = 16,
    parameter int MAX_PREFIX = 2
) (
    input  logic            cpu_clk,
    input  logic            cpu_reset_n,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    op_fetch_assembler_if.slave bus
);
    localparam logic [1:0] S_OP   = 2'd0;
    localparam logic [1:0] S_POST = 2'd1;
    localparam logic [1:0] S_OPHI = 2'd2;
    localparam logic [1:0] S_OPLO = 2'd3;

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int PFX_W = $clog2(MAX_PREFIX + 2);

    typedef struct packed {
        logic [1:0]      page;
        logic [7:0]      opcode;
        logic [7:0]      postbyte;
        logic [15:0]     operand;
        logic [2:0]      len;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } rec_t;

    // Shape of a page-1 opcode: {illegal, indexed, operand_count[1:0]}
    function automatic logic [3:0] decode_p1(input logic [7:0] op);
        logic [3:0] hi;
        logic [3:0] lo;
        logic [3:0] r;
        hi = op[7:4];
        lo = op[3:0];
        r  = 4'b0000;
        if (op == 8'h01 || op == 8'h02 || op == 8'h05 || op == 8'h0B ||
            op == 8'h14 || op == 8'h15 || op == 8'h18 || op == 8'h1B ||
            op == 8'h38 || op == 8'h3E)
            r = 4'b1000;
        else if (hi == 4'h6 || hi == 4'hA || hi == 4'hE || (op >= 8'h30 && op <= 8'h33))
            r = 4'b0100;
        else if (op == 8'h8D)
            r = 4'b0001;
        else if (hi == 4'h8 || hi == 4'hC)
            r = (lo == 4'h3 || lo == 4'hC || lo == 4'hE) ? 4'b0010 : 4'b0001;
        else if (hi == 4'h0 || hi == 4'h9 || hi == 4'hD || hi == 4'h2)
            r = 4'b0001;
        else if (hi == 4'h7 || hi == 4'hB || hi == 4'hF || op == 8'h16 || op == 8'h17)
            r = 4'b0010;
        else if (op == 8'h1A || op == 8'h1C || op == 8'h1E || op == 8'h1F ||
                 (op >= 8'h34 && op <= 8'h37) || op == 8'h3C)
            r = 4'b0001;
        return r;
    endfunction

    function automatic logic [3:0] decode_p23(input logic [7:0] op, input logic page3);
        logic [3:0] hi;
        logic [3:0] r;
        hi = op[7:4];
        r  = 4'b1000;
        if (!page3 && op >= 8'h21 && op <= 8'h2F)
            r = 4'b0010;
        else if (op == 8'h83 || op == 8'h8C || op == 8'h8E || op == 8'hCE ||
                 hi == 4'hB || hi == 4'hF)
            r = 4'b0010;
        else if (hi == 4'h9 || hi == 4'hD)
            r = 4'b0001;
        else if (hi == 4'hA || hi == 4'hE)
            r = 4'b0100;
        else if (op == 8'h3F)
            r = 4'b0000;
        return r;
    endfunction

    // Extra operand bytes implied by an indexed postbyte (offsets / extended indirect)
    function automatic logic [1:0] post_extra(input logic [7:0] pb);
        logic [1:0] r;
        r = 2'd0;
        if (pb[7]) begin
            if (pb[3:0] == 4'h8 || pb[3:0] == 4'hC)
                r = 2'd1;
            else if (pb[3:0] == 4'h9 || pb[3:0] == 4'hD || pb[4:0] == 5'h1F)
                r = 2'd2;
        end
        return r;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  start_pc_q, start_pc_d;
    logic [1:0]       page_q, page_d;
    logic [PFX_W-1:0] pfx_q, pfx_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [7:0]       post_q, post_d;
    logic [15:0]      operand_q, operand_d;
    logic [2:0]       len_q, len_d;
    logic             ill_q, ill_d;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    rec_t             q_mem_q [QDEPTH];

    logic       full;
    logic       accept;
    logic       fin;
    logic       push;
    logic       pop;
    logic [3:0] dec;
    logic [1:0] extra;
    logic [2:0] len_inc;
    rec_t       rec_d;
    rec_t       head;

    assign full   = (count_q == CNT_W'(QDEPTH));
    assign accept = bus.in_valid & bus.in_ready;
    assign push   = fin;
    assign pop    = bus.out_valid & bus.out_ready & ~flush;

    assign bus.in_ready = cpu_reset_n & ~full & ~flush;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        start_pc_d = start_pc_q;
        page_d     = page_q;
        pfx_d      = pfx_q;
        opcode_d   = opcode_q;
        post_d     = post_q;
        operand_d  = operand_q;
        len_d      = len_q;
        ill_d      = ill_q;
        fin        = 1'b0;
        dec        = 4'b0000;
        extra      = 2'd0;
        len_inc    = (len_q == 3'd7) ? 3'd7 : len_q + 3'd1;

        if (accept) begin
            pc_d  = pc_q + 1'b1;
            len_d = len_inc;
            case (state_q)
                S_OP: begin
                    if (bus.in_byte == 8'h10 || bus.in_byte == 8'h11) begin
                        page_d = bus.in_byte[0] ? 2'd3 : 2'd2;
                        pfx_d  = pfx_q + 1'b1;
                        if (int'(pfx_q) >= MAX_PREFIX) begin
                            ill_d = 1'b1;
                            fin   = 1'b1;
                        end
                    end else begin
                        opcode_d = bus.in_byte;
                        dec      = (page_q == 2'd0) ? decode_p1(bus.in_byte)
                                                    : decode_p23(bus.in_byte, page_q[0]);
                        ill_d    = dec[3];
                        if (dec[2])
                            state_d = S_POST;
                        else if (dec[1:0] == 2'd2)
                            state_d = S_OPHI;
                        else if (dec[1:0] == 2'd1)
                            state_d = S_OPLO;
                        else
                            fin = 1'b1;
                    end
                end
                S_POST: begin
                    post_d = bus.in_byte;
                    extra  = post_extra(bus.in_byte);
                    if (extra == 2'd2)
                        state_d = S_OPHI;
                    else if (extra == 2'd1)
                        state_d = S_OPLO;
                    else
                        fin = 1'b1;
                end
                S_OPHI: begin
                    operand_d[15:8] = bus.in_byte;
                    state_d         = S_OPLO;
                end
                default: begin
                    operand_d[7:0] = bus.in_byte;
                    fin            = 1'b1;
                end
            endcase
        end

        // Record captures this cycle's byte so the write costs no extra cycle
        rec_d.page     = page_d;
        rec_d.opcode   = opcode_d;
        rec_d.postbyte = post_d;
        rec_d.operand  = operand_d;
        rec_d.len      = len_d;
        rec_d.illegal  = ill_d;
        rec_d.pc       = start_pc_q;

        if (fin || flush) begin
            state_d   = S_OP;
            page_d    = 2'd0;
            pfx_d     = '0;
            opcode_d  = 8'h00;
            post_d    = 8'h00;
            operand_d = 16'h0000;
            len_d     = 3'd0;
            ill_d     = 1'b0;
        end
        if (fin)
            start_pc_d = pc_d;
        if (flush) begin
            pc_d       = flush_pc;
            start_pc_d = flush_pc;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)
                wr_ptr_d = (wr_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_d = (rd_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q    <= S_OP;
            pc_q       <= '0;
            start_pc_q <= '0;
            page_q     <= 2'd0;
            pfx_q      <= '0;
            opcode_q   <= 8'h00;
            post_q     <= 8'h00;
            operand_q  <= 16'h0000;
            len_q      <= 3'd0;
            ill_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            start_pc_q <= start_pc_d;
            page_q     <= page_d;
            pfx_q      <= pfx_d;
            opcode_q   <= opcode_d;
            post_q     <= post_d;
            operand_q  <= operand_d;
            len_q      <= len_d;
            ill_q      <= ill_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push)
            q_mem_q[wr_ptr_q] <= rec_d;
    end

    // Empty queue presents an all-zero head so stale entries never leak out
    assign head = (count_q != '0) ? q_mem_q[rd_ptr_q] : '0;

    assign bus.out_valid    = (count_q != '0);
    assign bus.out_page     = head.page;
    assign bus.out_opcode   = head.opcode;
    assign bus.out_postbyte = head.postbyte;
    assign bus.out_operand  = head.operand;
    assign bus.out_len      = head.len;
    assign bus.out_illegal  = head.illegal;
    assign bus.out_pc       = head.pc;
endmodule

// File: tb/tb_op_fetch_assembler.sv
// Randomized and directed checks of op_fetch_assembler against a
// length-rule reference model that assembles records from a byte queue.
module tb_op_fetch_assembler;
    localparam int QDEPTH     = 2;
    localparam int PC_W       = 16;
    localparam int MAX_PREFIX = 2;

    typedef struct packed {
        logic        ovf;
        logic [1:0]  page;
        logic [7:0]  opcode;
        logic [7:0]  post;
        logic [15:0] operand;
        logic [2:0]  len;
        logic        ill;
        logic [15:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            cpu_reset_n;
    logic            flush;
    logic [PC_W-1:0] flush_pc;

    op_fetch_assembler_if #(.PC_W(PC_W)) bus ();

    op_fetch_assembler #(.QDEPTH(QDEPTH), .PC_W(PC_W), .MAX_PREFIX(MAX_PREFIX)) dut (
        .cpu_clk     (clk),
        .cpu_reset_n (cpu_reset_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  pend[$];
    exp_t        sb[$];
    exp_t        got_log[$];
    logic [15:0] mpc;
    logic [15:0] start_pc;
    int          valid_pct;
    int          ready_pct;
    logic        flush_req;
    logic [15:0] flush_pc_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void shape(input logic [1:0] page, input logic [7:0] op,
                                  output logic ill, output logic idx, output int n);
        ill = 0; idx = 0; n = 0;
        if (page == 2'd0) begin
            case (op) inside
                8'h01, 8'h02, 8'h05, 8'h0B, 8'h14, 8'h15, 8'h18, 8'h1B, 8'h38, 8'h3E: ill = 1;
                [8'h30:8'h33]: idx = 1;
                8'h8D, 8'h1A, 8'h1C, 8'h1E, 8'h1F, [8'h34:8'h37], 8'h3C: n = 1;
                8'h16, 8'h17: n = 2;
                default:
                    case (op[7:4])
                        4'h0, 4'h2, 4'h9, 4'hD: n = 1;
                        4'h7, 4'hB, 4'hF:       n = 2;
                        4'h6, 4'hA, 4'hE:       idx = 1;
                        4'h8, 4'hC: n = (op[3:0] inside {4'h3, 4'hC, 4'hE}) ? 2 : 1;
                        default:                n = 0;
                    endcase
            endcase
        end else if (page == 2'd2 && op inside {[8'h21:8'h2F]}) begin
            n = 2;
        end else begin
            case (op) inside
                8'h83, 8'h8C, 8'h8E, 8'hCE: n = 2;
                8'h3F: n = 0;
                default:
                    case (op[7:4])
                        4'hB, 4'hF: n = 2;
                        4'h9, 4'hD: n = 1;
                        4'hA, 4'hE: idx = 1;
                        default:    ill = 1;
                    endcase
            endcase
        end
    endfunction

    function automatic int post_bytes(input logic [7:0] pb);
        if (!pb[7]) return 0;
        if (pb[3:0] == 4'h8 || pb[3:0] == 4'hC) return 1;
        if (pb[3:0] == 4'h9 || pb[3:0] == 4'hD || pb[4:0] == 5'h1F) return 2;
        return 0;
    endfunction

    // Returns 1 once the pending bytes form a complete instruction
    function automatic bit assemble(output exp_t r);
        int   p, n, total;
        logic ill, idx;
        p = 0;
        r = '0;
        r.pc = start_pc;
        while (p < pend.size() && (pend[p] == 8'h10 || pend[p] == 8'h11)) p++;
        if (p > MAX_PREFIX) begin
            r.ovf = 1; r.ill = 1; r.len = 3'(p);
            return 1;
        end
        if (pend.size() == p) return 0;
        r.page   = (p == 0) ? 2'd0 : ((pend[p-1] == 8'h11) ? 2'd3 : 2'd2);
        r.opcode = pend[p];
        shape(r.page, r.opcode, ill, idx, n);
        if (idx) begin
            if (pend.size() < p + 2) return 0;
            r.post = pend[p+1];
            n = post_bytes(r.post);
        end
        total = p + 1 + (idx ? 1 : 0) + n;
        if (pend.size() < total) return 0;
        if (n == 2) r.operand = {pend[total-2], pend[total-1]};
        else if (n == 1) r.operand = {8'h00, pend[total-1]};
        r.len = 3'((total > 7) ? 7 : total);
        r.ill = ill;
        return 1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        exp_t r;
        if (pend.size() == 0) start_pc = mpc;
        pend.push_back(b);
        mpc++;
        if (assemble(r)) begin
            sb.push_back(r);
            pend.delete();
        end
    endtask

    task automatic cycle();
        logic exp_ready, exp_valid;
        exp_t e, g;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        if (tx_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            bus.in_valid = 1'b1;
            bus.in_byte  = tx_q[0];
        end
        bus.out_ready = ($urandom_range(99) < ready_pct);
        flush     = flush_req;
        flush_pc  = flush_pc_req;
        flush_req = 1'b0;
        #1;
        exp_ready = (sb.size() < QDEPTH) && !flush;
        exp_valid = (sb.size() != 0);
        chk("in_ready", bus.in_ready, exp_ready);
        chk("out_valid", bus.out_valid, exp_valid);
        if (exp_valid && bus.out_ready && !flush) begin
            e = sb.pop_front();
            g = '0;
            g.page = bus.out_page; g.opcode = bus.out_opcode; g.post = bus.out_postbyte;
            g.operand = bus.out_operand; g.len = bus.out_len; g.ill = bus.out_illegal;
            g.pc = bus.out_pc;
            got_log.push_back(g);
            chk("pc", g.pc, e.pc);
            chk("len", g.len, e.len);
            chk("illegal", g.ill, e.ill);
            chk("postbyte", g.post, e.post);
            chk("operand", g.operand, e.operand);
            if (!e.ovf) begin
                chk("page", g.page, e.page);
                chk("opcode", g.opcode, e.opcode);
            end
        end
        if (flush) begin
            sb.delete();
            pend.delete();
            mpc = flush_pc;
        end else if (bus.in_valid && exp_ready) begin
            model_byte(bus.in_byte);
            void'(tx_q.pop_front());
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((tx_q.size() != 0 || sb.size() != 0) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_flush(input logic [15:0] addr);
        flush_req    = 1'b1;
        flush_pc_req = addr;
        cycle();
    endtask

    initial begin
        cpu_reset_n   = 1'b1;
        flush         = 1'b0;
        flush_pc      = '0;
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
        flush_req     = 1'b0;
        flush_pc_req  = '0;
        valid_pct     = 100;
        ready_pct     = 100;
        mpc           = 16'h0000;
        start_pc      = 16'h0000;

        #2 cpu_reset_n = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_len", bus.out_len, 3'd0);
        chk("rst_out_pc", bus.out_pc, 16'h0000);
        chk("rst_out_opcode", bus.out_opcode, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) cpu_reset_n = 1'b1;
        #1 chk("rel_in_ready", bus.in_ready, 1'b1);

        // Page-1 immediate after a flush to 0x1000
        do_flush(16'h1000);
        got_log.delete();
        tx_q = '{8'h86, 8'h42};
        run_until_idle(50);
        chk("t1_count", got_log.size(), 1);
        chk("t1_opcode", got_log[0].opcode, 8'h86);
        chk("t1_operand", got_log[0].operand, 16'h0042);
        chk("t1_len", got_log[0].len, 3'd2);
        chk("t1_pc", got_log[0].pc, 16'h1000);

        // Page-2 16-bit immediate
        got_log.delete();
        tx_q = '{8'h10, 8'h8E, 8'h12, 8'h34};
        run_until_idle(50);
        chk("t2_page", got_log[0].page, 2'd2);
        chk("t2_operand", got_log[0].operand, 16'h1234);
        chk("t2_len", got_log[0].len, 3'd4);
        chk("t2_illegal", got_log[0].ill, 1'b0);

        // Indexed with 16-bit offset, then plain indexed
        got_log.delete();
        tx_q = '{8'hA6, 8'h89, 8'h01, 8'h00, 8'h30, 8'h84};
        run_until_idle(50);
        chk("t3_count", got_log.size(), 2);
        chk("t3_post0", got_log[0].post, 8'h89);
        chk("t3_oper0", got_log[0].operand, 16'h0100);
        chk("t3_len0", got_log[0].len, 3'd4);
        chk("t3_post1", got_log[1].post, 8'h84);
        chk("t3_len1", got_log[1].len, 3'd2);
        chk("t3_oper1", got_log[1].operand, 16'h0000);

        // Back-pressure: full queue holds the third byte
        got_log.delete();
        ready_pct = 0;
        tx_q = '{8'h12, 8'h12, 8'h12};
        repeat (4) cycle();
        chk("t4_held", tx_q.size(), 1);
        ready_pct = 100;
        cycle();
        ready_pct = 0;
        cycle();
        chk("t4_accepted", tx_q.size(), 0);
        ready_pct = 100;
        run_until_idle(50);
        chk("t4_count", got_log.size(), 3);

        // Prefix overflow, then an undefined page-1 opcode
        got_log.delete();
        tx_q = '{8'h10, 8'h11, 8'h10, 8'h01};
        run_until_idle(50);
        chk("t5_ill0", got_log[0].ill, 1'b1);
        chk("t5_len0", got_log[0].len, 3'd3);
        chk("t5_ill1", got_log[1].ill, 1'b1);
        chk("t5_len1", got_log[1].len, 3'd1);

        // Flush drops a partial instruction
        got_log.delete();
        tx_q = '{8'hB6, 8'h12};
        run_until_idle(50);
        do_flush(16'h2000);
        tx_q = '{8'h4F};
        run_until_idle(50);
        chk("t6_count", got_log.size(), 1);
        chk("t6_len", got_log[0].len, 3'd1);
        chk("t6_pc", got_log[0].pc, 16'h2000);

        // Reset mid-instruction: next byte is an opcode at PC 0
        got_log.delete();
        tx_q = '{8'hB6};
        run_until_idle(50);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 cpu_reset_n = 1'b0;
        #1 chk("mid_rst_in_ready", bus.in_ready, 1'b0);
        sb.delete();
        pend.delete();
        mpc = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk) cpu_reset_n = 1'b1;
        tx_q = '{8'h4F};
        run_until_idle(50);
        chk("t7_opcode", got_log[0].opcode, 8'h4F);
        chk("t7_len", got_log[0].len, 3'd1);
        chk("t7_pc", got_log[0].pc, 16'h0000);

        // Random traffic with back-pressure and occasional flushes
        valid_pct = 80;
        ready_pct = 60;
        for (int i = 0; i < 3000; i++) begin
            while (tx_q.size() < 4) begin
                if ($urandom_range(99) < 8)
                    tx_q.push_back($urandom_range(1) ? 8'h11 : 8'h10);
                else
                    tx_q.push_back(8'($urandom_range(255)));
            end
            if ($urandom_range(99) < 1) begin
                flush_req    = 1'b1;
                flush_pc_req = 16'($urandom_range(16'hFFFF));
            end
            cycle();
        end
        ready_pct = 100;
        valid_pct = 100;
        run_until_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
